// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption core: one InvSubBytes stage shared by all ten rounds,
// alternating SUB (S-box capture) and MIX (key add + InvMixColumns) cycles.

package aes_decrypt_core_pkg;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0, which is what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [7:0] v;
        v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

endpackage

// Sixteen S-boxes with a registered output; no reset because every consumer
// waits for a capture cycle before using the result.
module subBytesAll (
    input  logic         clk,
    input  logic         en,
    input  logic         inverse,
    input  logic [127:0] din,
    output logic [127:0] dout
);
    import aes_decrypt_core_pkg::*;

    logic [7:0] q_reg [16];

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_byte
        always_ff @(posedge clk) begin
            if (en) begin
                q_reg[gi] <= inverse ? sbox_inv(din[8*gi +: 8]) : sbox_fwd(din[8*gi +: 8]);
            end
        end
        assign dout[8*gi +: 8] = q_reg[gi];
    end
endmodule

module aes_decrypt_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] cipherIn,
    input  logic [127:0] roundKey,
    output logic [3:0]   keyIdx,
    output logic         ready,
    output logic         done,
    output logic [127:0] plainOut
);
    import aes_decrypt_core_pkg::*;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2
    } fsm_t;

    fsm_t         fsm_reg;
    logic [127:0] state_reg;
    logic [3:0]   round_reg;
    logic [3:0]   key_idx_reg;
    logic         ready_reg;
    logic         done_reg;
    logic [127:0] plain_reg;

    logic [127:0] sub_in;
    logic [127:0] sub_out;
    logic [127:0] add_key;
    logic [127:0] mix_out;

    // InvShiftRows is pure wiring: byte (r,c) takes byte (r,(c-r) mod 4).
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_isr
        localparam int ROW = gi % 4;
        localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
        assign sub_in[127-8*gi -: 8] = state_reg[127-8*SRC -: 8];
    end

    subBytesAll u_sbox (
        .clk     (clk),
        .en      (1'b1),
        .inverse (1'b1),
        .din     (sub_in),
        .dout    (sub_out)
    );

    assign add_key = sub_out ^ roundKey;

    for (gi = 0; gi < 4; gi++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign a0 = add_key[127-32*gi -: 8];
        assign a1 = add_key[119-32*gi -: 8];
        assign a2 = add_key[111-32*gi -: 8];
        assign a3 = add_key[103-32*gi -: 8];
        assign mix_out[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign mix_out[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign mix_out[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign mix_out[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

    // keyIdx tracks round_reg while busy so the external key store answers in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg     <= IDLE;
            state_reg   <= '0;
            round_reg   <= 4'd0;
            key_idx_reg <= 4'hA;
            ready_reg   <= 1'b1;
            done_reg    <= 1'b0;
            plain_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= cipherIn ^ roundKey;
                        round_reg   <= 4'd9;
                        key_idx_reg <= 4'd9;
                        ready_reg   <= 1'b0;
                        fsm_reg     <= SUB;
                    end
                end
                SUB: begin
                    fsm_reg <= MIX;
                end
                MIX: begin
                    if (round_reg != 4'd0) begin
                        state_reg   <= mix_out;
                        round_reg   <= round_reg - 4'd1;
                        key_idx_reg <= round_reg - 4'd1;
                        fsm_reg     <= SUB;
                    end else begin
                        plain_reg   <= add_key;
                        done_reg    <= 1'b1;
                        key_idx_reg <= 4'hA;
                        ready_reg   <= 1'b1;
                        fsm_reg     <= IDLE;
                    end
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

    assign keyIdx   = key_idx_reg;
    assign ready    = ready_reg;
    assign done     = done_reg;
    assign plainOut = plain_reg;

endmodule
